// File: rtl/adder_mul_sequencer.sv
// Multi-cycle 32x32->64 shift-add multiplier built around a single shared 32-bit adder.
// Optional two's-complement mode is enabled by defining MUL_SIGNED_EN.

module adder_mul_adder32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {32'd0, cin};
endmodule

module adder_mul_sequencer #(
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic        hi_nz
);
    localparam int N_ITER = 32;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER);

`ifdef MUL_SIGNED_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREPA = 3'd1,
        PREPB = 3'd2,
        RUN   = 3'd3,
        NEGL  = 3'd4,
        NEGH  = 3'd5,
        DONE  = 3'd6
    } state_t;
    localparam state_t FIRST_ST  = PREPA;
    localparam state_t AFTER_RUN = NEGL;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam state_t FIRST_ST  = RUN;
    localparam state_t AFTER_RUN = DONE;
`endif

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       mcand_r;
    logic [31:0]       mult_r;
    logic [31:0]       acc_hi_r;
    logic [31:0]       acc_lo_r;
    logic              busy_r;
    logic              done_r;
    logic [63:0]       product_r;
    logic              hi_nz_r;
`ifdef MUL_SIGNED_EN
    logic              neg_r;
    logic              negc_r;
`endif

    logic [31:0]       add_x_s;
    logic [31:0]       add_y_s;
    logic              add_cin_s;
    logic [31:0]       add_sum_s;
    logic              add_cout_s;
    logic [32:0]       step_s;
    logic [63:0]       commit_val_s;

    // Upper half is significant unless it is just the extension of the lower half.
    function automatic logic calc_hi_nz(input logic [63:0] p);
`ifdef MUL_SIGNED_EN
        calc_hi_nz = (p[63:32] != {32{p[31]}});
`else
        calc_hi_nz = (p[63:32] != 32'd0);
`endif
    endfunction

    adder_mul_adder32 u_adder (
        .x    (add_x_s),
        .y    (add_y_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Carry-out is kept as the 33rd bit so it shifts into the accumulator top.
    assign step_s = mult_r[0] ? {add_cout_s, add_sum_s} : {1'b0, acc_hi_r};

    // Next-state decode, adder operand steering and result selection.
    always_comb begin
        next_state_s = state_r;
        add_x_s      = acc_hi_r;
        add_y_s      = mcand_r;
        add_cin_s    = 1'b0;
        commit_val_s = {acc_hi_r, acc_lo_r};
        case (state_r)
            IDLE, DONE: begin
                if (start) next_state_s = FIRST_ST;
                else       next_state_s = IDLE;
            end
            RUN: begin
                if (cnt_r == LAST_CNT) next_state_s = AFTER_RUN;
                else                   next_state_s = RUN;
            end
`ifdef MUL_SIGNED_EN
            PREPA: begin
                add_x_s      = ~mcand_r;
                add_y_s      = 32'd0;
                add_cin_s    = 1'b1;
                next_state_s = PREPB;
            end
            PREPB: begin
                add_x_s      = ~mult_r;
                add_y_s      = 32'd0;
                add_cin_s    = 1'b1;
                next_state_s = RUN;
            end
            NEGL: begin
                add_x_s      = ~acc_lo_r;
                add_y_s      = 32'd0;
                add_cin_s    = 1'b1;
                next_state_s = NEGH;
            end
            NEGH: begin
                add_x_s      = ~acc_hi_r;
                add_y_s      = 32'd0;
                add_cin_s    = negc_r;
                next_state_s = DONE;
                if (neg_r) commit_val_s = {add_sum_s, acc_lo_r};
                else       commit_val_s = {acc_hi_r, acc_lo_r};
            end
`endif
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_s;
    end

    // Operand capture, shift-add iterations and sign handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            mcand_r  <= 32'd0;
            mult_r   <= 32'd0;
            acc_hi_r <= 32'd0;
            acc_lo_r <= 32'd0;
`ifdef MUL_SIGNED_EN
            neg_r    <= 1'b0;
            negc_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_r  <= a;
                        mult_r   <= b;
                        acc_hi_r <= 32'd0;
                        acc_lo_r <= 32'd0;
                        cnt_r    <= '0;
`ifdef MUL_SIGNED_EN
                        neg_r    <= a[31] ^ b[31];
`endif
                    end
                end
                RUN: begin
                    if (cnt_r != LAST_CNT) begin
                        acc_hi_r <= step_s[32:1];
                        acc_lo_r <= {step_s[0], acc_lo_r[31:1]};
                        mult_r   <= {acc_lo_r[0], mult_r[31:1]};
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
`ifdef MUL_SIGNED_EN
                // 0x80000000 negates to itself and is then used as an unsigned magnitude.
                PREPA: if (mcand_r[31]) mcand_r <= add_sum_s;
                PREPB: if (mult_r[31])  mult_r  <= add_sum_s;
                NEGL: begin
                    if (neg_r) begin
                        acc_lo_r <= add_sum_s;
                        negc_r   <= add_cout_s;
                    end else begin
                        negc_r   <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Registered outputs; done and the result land together on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= 64'd0;
            hi_nz_r   <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE) && (next_state_s != DONE);
            done_r <= (next_state_s == DONE);
            if (next_state_s == DONE) begin
                product_r <= commit_val_s;
                hi_nz_r   <= calc_hi_nz(commit_val_s);
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;
    assign hi_nz   = hi_nz_r;

endmodule

// File: tb/tb_adder_mul_sequencer.sv
// Directed self-checking bench for adder_mul_sequencer with hand-computed products.
// Define MUL_SIGNED_EN for both bench and design to exercise the signed build.

module tb_adder_mul_sequencer;
`ifdef MUL_SIGNED_EN
    localparam int LAT = 37;
`else
    localparam int LAT = 33;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        hi_nz;

    int n_cmp = 0;
    int n_mis = 0;

    adder_mul_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .hi_nz   (hi_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and returns during the cycle done is high.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp_p, input logic exp_h, input bit repulse);
        int lat;
        lat   = 0;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".busy"}, {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            if (repulse && i == 5) begin
                a     = 32'd5;
                b     = 32'd7;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (repulse && i == 5) check({tag, ".busy_repulse"}, {63'd0, busy}, 64'd1);
            if (done) lat = i;
        end
        check({tag, ".latency"}, 64'(lat), 64'(LAT));
        check({tag, ".product"}, product, exp_p);
        check({tag, ".hi_nz"}, {63'd0, hi_nz}, {63'd0, exp_h});
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.done", {63'd0, done}, 64'd0);
        check("reset.product", product, 64'd0);
        check("reset.hi_nz", {63'd0, hi_nz}, 64'd0);

        // T1: small operands, then done must drop and the product hold.
        run_op("t1", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 1'b0);
        tick();
        check("t1.done_pulse", {63'd0, done}, 64'd0);
        check("t1.hold", product, 64'h0000_0000_0000_000F);

        // T2: all-ones operands keep the adder carry-out busy.
`ifdef MUL_SIGNED_EN
        run_op("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
`else
        run_op("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
`endif
        tick();

        // T4: reset in the middle of an operation discards it.
        a     = 32'h0001_0000;
        b     = 32'h0001_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4.busy", {63'd0, busy}, 64'd0);
        check("t4.done", {63'd0, done}, 64'd0);
        check("t4.product", product, 64'd0);
        check("t4.hi_nz", {63'd0, hi_nz}, 64'd0);
        pulses = 0;
        repeat (50) begin
            tick();
            if (done) pulses++;
        end
        check("t4.no_done", 64'(pulses), 64'd0);

        // T3: zero multiplicand, fixed latency, re-pulsed start ignored.
        run_op("t3", 32'd0, 32'h1234_5678, 64'd0, 1'b0, 1'b1);
        tick();

        // T5: back-to-back, second start issued in the done cycle.
        run_op("t5a", 32'd7, 32'd9, 64'd63, 1'b0, 1'b0);
        run_op("t5b", 32'd2, 32'd2, 64'd4, 1'b0, 1'b0);
        tick();

`ifdef MUL_SIGNED_EN
        // T6: negative times positive.
        run_op("t6", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0);
        tick();
        run_op("t6b", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
